// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
// Game-flow controller for the memory-pattern game. Each round it shows the
// first round_len pattern entries one at a time, then hands control to the
// player-input phase. It times the per-press input window and the GOOD/LOSE
// pauses, decides GOOD/LOSE/WIN and reports the final score. All timing
// advances only on the level-rate tick enable. The exceptions are the
// player-input decisions and the WAIT_LOAD exit, which are evaluated on
// every clk.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   tick            one-cycle enable at the level rate
//   start, abort    one-cycle control pulses (abort wins over start)
//   pat_ready       pattern table fully loaded
//   press_valid     one-cycle pulse per debounced press
//   press_correct   press_valid qualifier: button matches entry expect_idx
//   show_on         entry pat_idx is being displayed
//   pat_idx         entry currently shown
//   expect_idx      entry the player must enter next
//   round_len       entries in the current round
//   in_input        high while waiting for player presses
//   msg_sel         0=blank 1=GOOD 2=LOSE 3=WIN
//   game_over       one-cycle pulse on entering OVER
//   score           completed rounds, valid from game_over until next start
// -----------------------------------------------------------------------------
module round_sequencer #(
  parameter int PAT_LEN       = 50,
  parameter int IDX_W         = 6,
  parameter int START_LEN     = 1,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 3,
  parameter int PAUSE_TICKS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             pat_ready,
  input  logic             press_valid,
  input  logic             press_correct,
  output logic             show_on,
  output logic [IDX_W-1:0] pat_idx,
  output logic [IDX_W-1:0] expect_idx,
  output logic [IDX_W-1:0] round_len,
  output logic             in_input,
  output logic [1:0]       msg_sel,
  output logic             game_over,
  output logic [IDX_W-1:0] score
);

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHOW_ON    = 3'd2;
  localparam logic [2:0] ST_SHOW_OFF   = 3'd3;
  localparam logic [2:0] ST_INPUT      = 3'd4;
  localparam logic [2:0] ST_PAUSE_GOOD = 3'd5;
  localparam logic [2:0] ST_PAUSE_LOSE = 3'd6;
  localparam logic [2:0] ST_OVER       = 3'd7;

  localparam logic [1:0] MSG_BLANK = 2'd0;
  localparam logic [1:0] MSG_GOOD  = 2'd1;
  localparam logic [1:0] MSG_LOSE  = 2'd2;
  localparam logic [1:0] MSG_WIN   = 2'd3;

  // Phase counters load (count-1) and expire on the tick that sees zero.
  // The input timer instead holds the full tick count and times out on
  // the tick that sees one, so a reload restores the whole window.
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LOAD      = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD     = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PAUSE_LOAD   = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_TICKS);

  localparam logic [IDX_W-1:0] IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] START_RL    = IDX_W'(START_LEN);
  localparam logic [IDX_W-1:0] PAT_LEN_IDX = IDX_W'(PAT_LEN);

  logic [2:0]       state_r, state_s, nxt_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, nxt_cnt_s;
  logic [IDX_W-1:0] pat_idx_r, pat_idx_s, nxt_pat_idx_s;
  logic [IDX_W-1:0] expect_idx_r, expect_idx_s, nxt_expect_idx_s;
  logic [IDX_W-1:0] round_len_r, round_len_s, nxt_round_len_s;
  logic [1:0]       msg_sel_r, msg_sel_s, nxt_msg_sel_s;
  logic [IDX_W-1:0] score_r, score_s, nxt_score_s;
  logic             show_on_r, in_input_r, game_over_r;
  logic             last_show_s, last_expect_s;

  assign last_show_s   = (pat_idx_r == (round_len_r - IDX_ONE));
  assign last_expect_s = (expect_idx_r == (round_len_r - IDX_ONE));

  // Round FSM: next state, counter and datapath values (abort handled later).
  always_comb begin
    nxt_state_s      = state_r;
    nxt_cnt_s        = cnt_r;
    nxt_pat_idx_s    = pat_idx_r;
    nxt_expect_idx_s = expect_idx_r;
    nxt_round_len_s  = round_len_r;
    nxt_msg_sel_s    = msg_sel_r;
    nxt_score_s      = score_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          nxt_score_s      = IDX_ZERO;
          nxt_msg_sel_s    = MSG_BLANK;
          nxt_pat_idx_s    = IDX_ZERO;
          nxt_expect_idx_s = IDX_ZERO;
          if (pat_ready) begin
            nxt_state_s     = ST_SHOW_ON;
            nxt_cnt_s       = ON_LOAD;
            nxt_round_len_s = START_RL;
          end else begin
            nxt_state_s = ST_WAIT_LOAD;
            nxt_cnt_s   = CNT_ZERO;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        // Leaves as soon as the table is loaded, independent of tick.
        if (pat_ready) begin
          nxt_state_s     = ST_SHOW_ON;
          nxt_cnt_s       = ON_LOAD;
          nxt_round_len_s = START_RL;
        end else begin
          nxt_state_s = ST_WAIT_LOAD;
        end
      end
      ST_SHOW_ON: begin
        if (tick) begin
          if (cnt_r == CNT_ZERO) begin
            nxt_state_s = ST_SHOW_OFF;
            nxt_cnt_s   = OFF_LOAD;
          end else begin
            nxt_cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          nxt_cnt_s = cnt_r;
        end
      end
      ST_SHOW_OFF: begin
        if (tick) begin
          if (cnt_r == CNT_ZERO) begin
            if (last_show_s) begin
              nxt_state_s      = ST_INPUT;
              nxt_cnt_s        = TIMEOUT_LOAD;
              nxt_pat_idx_s    = IDX_ZERO;
              nxt_expect_idx_s = IDX_ZERO;
            end else begin
              nxt_state_s   = ST_SHOW_ON;
              nxt_cnt_s     = ON_LOAD;
              nxt_pat_idx_s = pat_idx_r + IDX_ONE;
            end
          end else begin
            nxt_cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          nxt_cnt_s = cnt_r;
        end
      end
      ST_INPUT: begin
        nxt_msg_sel_s = MSG_BLANK;
        // A press is decided before the tick, so a press in the timeout
        // cycle wins over the timeout.
        if (press_valid) begin
          if (press_correct) begin
            if (last_expect_s) begin
              nxt_state_s   = ST_PAUSE_GOOD;
              nxt_cnt_s     = PAUSE_LOAD;
              nxt_msg_sel_s = MSG_GOOD;
            end else begin
              nxt_expect_idx_s = expect_idx_r + IDX_ONE;
              nxt_cnt_s        = TIMEOUT_LOAD;
            end
          end else begin
            nxt_state_s   = ST_PAUSE_LOSE;
            nxt_cnt_s     = PAUSE_LOAD;
            nxt_msg_sel_s = MSG_LOSE;
          end
        end else if (tick) begin
          if (cnt_r <= CNT_ONE) begin
            nxt_state_s   = ST_PAUSE_LOSE;
            nxt_cnt_s     = PAUSE_LOAD;
            nxt_msg_sel_s = MSG_LOSE;
          end else begin
            nxt_cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          nxt_cnt_s = cnt_r;
        end
      end
      ST_PAUSE_GOOD: begin
        if (tick) begin
          if (cnt_r == CNT_ZERO) begin
            nxt_score_s = round_len_r;
            // Checked before incrementing so round_len never passes PAT_LEN.
            if (round_len_r >= PAT_LEN_IDX) begin
              nxt_state_s   = ST_OVER;
              nxt_cnt_s     = CNT_ZERO;
              nxt_msg_sel_s = MSG_WIN;
            end else begin
              nxt_state_s     = ST_SHOW_ON;
              nxt_cnt_s       = ON_LOAD;
              nxt_round_len_s = round_len_r + IDX_ONE;
              nxt_pat_idx_s   = IDX_ZERO;
              nxt_msg_sel_s   = MSG_BLANK;
            end
          end else begin
            nxt_cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          nxt_cnt_s = cnt_r;
        end
      end
      ST_PAUSE_LOSE: begin
        if (tick) begin
          if (cnt_r == CNT_ZERO) begin
            nxt_state_s = ST_OVER;
            nxt_cnt_s   = CNT_ZERO;
          end else begin
            nxt_cnt_s = cnt_r - CNT_ONE;
          end
        end else begin
          nxt_cnt_s = cnt_r;
        end
      end
      ST_OVER: begin
        // msg_sel and score hold so the result stays on display.
        if (start && pat_ready) begin
          nxt_state_s      = ST_SHOW_ON;
          nxt_cnt_s        = ON_LOAD;
          nxt_round_len_s  = START_RL;
          nxt_pat_idx_s    = IDX_ZERO;
          nxt_expect_idx_s = IDX_ZERO;
          nxt_score_s      = IDX_ZERO;
          nxt_msg_sel_s    = MSG_BLANK;
        end else begin
          nxt_state_s = ST_OVER;
        end
      end
      default: begin
        nxt_state_s      = ST_IDLE;
        nxt_cnt_s        = CNT_ZERO;
        nxt_pat_idx_s    = IDX_ZERO;
        nxt_expect_idx_s = IDX_ZERO;
        nxt_round_len_s  = IDX_ZERO;
        nxt_msg_sel_s    = MSG_BLANK;
        nxt_score_s      = score_r;
      end
    endcase
  end

  // Abort override: back to IDLE with reset values, keeping the score.
  always_comb begin
    if (abort) begin
      state_s      = ST_IDLE;
      cnt_s        = CNT_ZERO;
      pat_idx_s    = IDX_ZERO;
      expect_idx_s = IDX_ZERO;
      round_len_s  = IDX_ZERO;
      msg_sel_s    = MSG_BLANK;
      score_s      = score_r;
    end else begin
      state_s      = nxt_state_s;
      cnt_s        = nxt_cnt_s;
      pat_idx_s    = nxt_pat_idx_s;
      expect_idx_s = nxt_expect_idx_s;
      round_len_s  = nxt_round_len_s;
      msg_sel_s    = nxt_msg_sel_s;
      score_s      = nxt_score_s;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      pat_idx_r    <= IDX_ZERO;
      expect_idx_r <= IDX_ZERO;
      round_len_r  <= IDX_ZERO;
      msg_sel_r    <= MSG_BLANK;
      score_r      <= IDX_ZERO;
      show_on_r    <= 1'b0;
      in_input_r   <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pat_idx_r    <= pat_idx_s;
      expect_idx_r <= expect_idx_s;
      round_len_r  <= round_len_s;
      msg_sel_r    <= msg_sel_s;
      score_r      <= score_s;
      show_on_r    <= (state_s == ST_SHOW_ON);
      in_input_r   <= (state_s == ST_INPUT);
      game_over_r  <= (state_s == ST_OVER) && (state_r != ST_OVER);
    end
  end

  assign show_on    = show_on_r;
  assign pat_idx    = pat_idx_r;
  assign expect_idx = expect_idx_r;
  assign round_len  = round_len_r;
  assign in_input   = in_input_r;
  assign msg_sel    = msg_sel_r;
  assign game_over  = game_over_r;
  assign score      = score_r;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Central game-flow controller for the memory-pattern game. It sequences each round: show the first N pattern entries one at a time, then hand control to the player-input phase, and count the input-timeout and result pauses. It decides GOOD/LOSE/WIN and reports the final score. It drives the pattern-display index and the verify index used by the display/verify datapath. All timing runs on the level-rate tick enable, so one fast clock serves every difficulty level.

Parameters:
PAT_LEN, 50, number of stored pattern entries; maximum round length
IDX_W, 6, width of the index and score fields; must hold PAT_LEN
START_LEN, 1, number of entries shown in round 1
ON_TICKS, 2, ticks each pattern entry is lit
OFF_TICKS, 1, blank ticks after each entry
TIMEOUT_TICKS, 3, ticks allowed per player press; reloaded after every correct press
PAUSE_TICKS, 2, ticks GOOD/LOSE is held before the next action

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle enable at the level rate
start  in  1  one-cycle pulse: begin a new game
abort  in  1  one-cycle pulse: return to IDLE from any state
pat_ready  in  1  high once the pattern table is fully loaded
press_valid  in  1  one-cycle pulse per debounced single-button press
press_correct  in  1  qualifies press_valid: the pressed button matches entry expect_idx
show_on  out  1  high while entry pat_idx is displayed
pat_idx  out  IDX_W  entry currently shown
expect_idx  out  IDX_W  entry the player must enter next
round_len  out  IDX_W  entries in the current round
in_input  out  1  high in the INPUT state
msg_sel  out  2  0=blank, 1=GOOD, 2=LOSE, 3=WIN
game_over  out  1  one-cycle pulse on entering OVER
score  out  IDX_W  completed rounds; valid from game_over until the next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0 and the internal tick counter is 0. Reset has priority over every other input.
- The FSM updates only on clk. Unless stated otherwise, transitions happen on the cycle where tick=1 and the tick counter expires.
- Counter loading: the tick counter loads (count-1) on state entry. It decrements on each tick, and the state expires on the tick that sees 0.
- IDLE:
  - start=1 and pat_ready=1 -> SHOW_ON. round_len=START_LEN, pat_idx=0, score=0, msg_sel=0.
  - start=1 and pat_ready=0 -> WAIT_LOAD.
- WAIT_LOAD: -> SHOW_ON on the first cycle with pat_ready=1. This transition is not tick-gated.
- SHOW_ON: show_on=1 for ON_TICKS ticks, then -> SHOW_OFF.
- SHOW_OFF: show_on=0 for OFF_TICKS ticks. On expiry:
  - if pat_idx==round_len-1 -> INPUT, with expect_idx=0, timer=TIMEOUT_TICKS, pat_idx=0;
  - otherwise pat_idx+1 -> SHOW_ON.
- INPUT: in_input=1, msg_sel=0. Evaluated every clk, not tick-gated.
  - press_valid & press_correct:
    - if expect_idx==round_len-1 -> PAUSE_GOOD;
    - otherwise expect_idx+1 and the timer reloads.
  - press_valid & ~press_correct -> PAUSE_LOSE.
  - A tick with timer==1 and no press -> PAUSE_LOSE. Otherwise each tick decrements the timer.
  - A press and a timeout tick in the same cycle: the press wins.
- PAUSE_GOOD: msg_sel=1 for PAUSE_TICKS ticks. On expiry score=round_len, then:
  - if round_len==PAT_LEN -> OVER with msg_sel=3;
  - otherwise round_len+1, pat_idx=0 -> SHOW_ON.
- PAUSE_LOSE: msg_sel=2 for PAUSE_TICKS ticks, then -> OVER. score is unchanged, i.e. round_len-1 relative to the failed round.
- OVER:
  - game_over=1 for exactly the entry cycle.
  - msg_sel and score hold their values.
  - start -> SHOW_ON as from IDLE (score cleared), provided pat_ready=1.
- abort in any state -> IDLE next cycle. Outputs go to reset values except score, which holds. abort beats start if both are asserted.
- start outside IDLE/OVER is ignored. press_valid outside INPUT is ignored.
- Width rules: every increment is checked before it happens, so nothing wraps. round_len never exceeds PAT_LEN.

Test Plan:
- Defaults, pat_ready=1, start; no presses -> show_on high 2 ticks for pat_idx 0, blank 1 tick, then INPUT. 3 ticks later msg_sel=2; 2 ticks later game_over pulse with score=0.
- Round 1 correct press, round 2 presses correct, correct -> round_len goes 1 -> 2 -> 3. pat_idx sequence in round 2 is 0,1. score=2 after the second PAUSE_GOOD.
- Round 2: correct press, then wrong press -> PAUSE_LOSE immediately (same clk, no tick needed). game_over pulse, score=1.
- A correct press arriving in the same cycle as the timer-expiry tick -> expect_idx advances and there is no LOSE.
- PAT_LEN=3, all rounds correct -> after round 3 the FSM enters OVER with msg_sel=3, score=3, and round_len stays 3.
- rst_n low mid-SHOW_ON -> all outputs 0 asynchronously. abort during INPUT -> IDLE with score held. start with pat_ready=0 -> WAIT_LOAD until pat_ready=1.
